// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light controller front end: default
// debounce length, arrival counter width and direction indices.
package traffic_pkg;

   localparam int DEB_CYCLES_DEFAULT = 4;
   localparam int CNT_W_DEFAULT      = 8;
   localparam int DCNT_W             = 8;

   localparam int DIR1 = 0;
   localparam int DIR2 = 1;
   localparam int NUM_DIRS = 2;

endpackage : traffic_pkg

// File: rtl/sensor_conditioner_if.sv
// Bundle of detector inputs, controller handshake and maintenance readout
// between the roadside sensor front end and its user.
interface sensor_conditioner_if
   import traffic_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
);

   logic             raw1;
   logic             raw2;
   logic             clr1;
   logic             clr2;
   logic             count_clr;
   logic             sensor1;
   logic             sensor2;
   logic             present1;
   logic             present2;
   logic             arrival1;
   logic             arrival2;
   logic [CNT_W-1:0] count1;
   logic [CNT_W-1:0] count2;

   // Controller / environment side: drives detectors and clears, reads status.
   modport master (
      output raw1, raw2, clr1, clr2, count_clr,
      input  sensor1, sensor2, present1, present2,
      input  arrival1, arrival2, count1, count2
   );

   // Conditioner side.
   modport slave (
      input  raw1, raw2, clr1, clr2, count_clr,
      output sensor1, sensor2, present1, present2,
      output arrival1, arrival2, count1, count2
   );

endinterface : sensor_conditioner_if

// File: rtl/sensor_channel.sv
// One detector channel: two-flop synchroniser, symmetric debounce filter,
// arrival pulse, pending-request latch and saturating arrival counter.
module sensor_channel
   import traffic_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter int CNT_W      = CNT_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             raw_i,
   input  logic             clr_i,
   input  logic             count_clr_i,
   output logic             sensor_o,
   output logic             present_o,
   output logic             arrival_o,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [DCNT_W-1:0] DEB_LAST  = DCNT_W'(DEB_CYCLES - 1);
   localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
   localparam logic [DCNT_W-1:0] DCNT_ONE  = {{(DCNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic              sync1_q;
   logic              sync2_q;
   logic [DCNT_W-1:0] dcnt_q;
   logic [DCNT_W-1:0] dcnt_d;
   logic              present_q;
   logic              present_d;
   logic              arrival_q;
   logic              arrival_d;
   logic              sensor_q;
   logic              sensor_d;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;

   // Bring the asynchronous detector line into the clock domain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: the level must differ from present for DEB_CYCLES straight cycles.
   always_comb begin
      dcnt_d    = dcnt_q;
      present_d = present_q;
      if (sync2_q == present_q) begin
         dcnt_d = DCNT_ZERO;
      end else if (dcnt_q == DEB_LAST) begin
         present_d = sync2_q;
         dcnt_d    = DCNT_ZERO;
      end else begin
         dcnt_d = dcnt_q + DCNT_ONE;
      end
   end

   // Arrival pulse, request latch (set beats clear) and saturating counter.
   always_comb begin
      arrival_d = present_d & ~present_q;

      if (arrival_q) begin
         sensor_d = 1'b1;
      end else if (clr_i) begin
         sensor_d = 1'b0;
      end else begin
         sensor_d = sensor_q;
      end

      if (count_clr_i) begin
         count_d = CNT_ZERO;
      end else if (arrival_q && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Channel state registers; reset drops partial debounce and pending request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dcnt_q    <= DCNT_ZERO;
         present_q <= 1'b0;
         arrival_q <= 1'b0;
         sensor_q  <= 1'b0;
         count_q   <= CNT_ZERO;
      end else begin
         dcnt_q    <= dcnt_d;
         present_q <= present_d;
         arrival_q <= arrival_d;
         sensor_q  <= sensor_d;
         count_q   <= count_d;
      end
   end

   assign sensor_o  = sensor_q;
   assign present_o = present_q;
   assign arrival_o = arrival_q;
   assign count_o   = count_q;

endmodule : sensor_channel

// File: rtl/sensor_conditioner.sv
// Front end of the traffic light controller: two independent detector
// channels producing the sensor1/sensor2 request levels. Wiring only.
module sensor_conditioner
   import traffic_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter int CNT_W      = CNT_W_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   sensor_conditioner_if.slave  bus
);

   logic [NUM_DIRS-1:0] raw_s;
   logic [NUM_DIRS-1:0] clr_s;
   logic [NUM_DIRS-1:0] sensor_s;
   logic [NUM_DIRS-1:0] present_s;
   logic [NUM_DIRS-1:0] arrival_s;
   logic [CNT_W-1:0]    count_s [NUM_DIRS];

   assign raw_s[DIR1] = bus.raw1;
   assign raw_s[DIR2] = bus.raw2;
   assign clr_s[DIR1] = bus.clr1;
   assign clr_s[DIR2] = bus.clr2;

   for (genvar g = 0; g < NUM_DIRS; g++) begin : g_ch
      sensor_channel #(
         .DEB_CYCLES (DEB_CYCLES),
         .CNT_W      (CNT_W)
      ) u_ch (
         .clk_i       (clock),
         .rst_ni      (reset),
         .raw_i       (raw_s[g]),
         .clr_i       (clr_s[g]),
         .count_clr_i (bus.count_clr),
         .sensor_o    (sensor_s[g]),
         .present_o   (present_s[g]),
         .arrival_o   (arrival_s[g]),
         .count_o     (count_s[g])
      );
   end

   assign bus.sensor1  = sensor_s[DIR1];
   assign bus.sensor2  = sensor_s[DIR2];
   assign bus.present1 = present_s[DIR1];
   assign bus.present2 = present_s[DIR2];
   assign bus.arrival1 = arrival_s[DIR1];
   assign bus.arrival2 = arrival_s[DIR2];
   assign bus.count1   = count_s[DIR1];
   assign bus.count2   = count_s[DIR2];

endmodule : sensor_conditioner

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEB_CYCLES=4, CNT_W=8.
module tb_sensor_conditioner;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   sensor_conditioner_if #(.CNT_W(8)) bus_if ();

   sensor_conditioner #(
      .DEB_CYCLES (4),
      .CNT_W      (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_sensor1"},  bus_if.sensor1,  1'b0);
      chk1({tag, "_sensor2"},  bus_if.sensor2,  1'b0);
      chk1({tag, "_present1"}, bus_if.present1, 1'b0);
      chk1({tag, "_present2"}, bus_if.present2, 1'b0);
      chk1({tag, "_arrival1"}, bus_if.arrival1, 1'b0);
      chk1({tag, "_arrival2"}, bus_if.arrival2, 1'b0);
      chk8({tag, "_count1"},   bus_if.count1,   8'd0);
      chk8({tag, "_count2"},   bus_if.count2,   8'd0);
   endtask

   // One debounced press on raw2: high for 6 samples, then low long enough to settle.
   task automatic press2();
      bus_if.raw2 = 1'b1;
      repeat (6) tick();
      bus_if.raw2 = 1'b0;
      repeat (7) tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      bus_if.raw1      = 1'b0;
      bus_if.raw2      = 1'b0;
      bus_if.clr1      = 1'b0;
      bus_if.clr2      = 1'b0;
      bus_if.count_clr = 1'b0;

      // Reset held low: outputs zero without any clock edge, then with activity.
      #1;
      chk_all_zero("rst_noclk");
      bus_if.raw1 = 1'b1;
      bus_if.raw2 = 1'b1;
      repeat (8) tick();
      bus_if.raw1 = 1'b0;
      repeat (2) tick();
      chk_all_zero("rst_toggle");

      // Release: nothing asserts without a completed debounce.
      bus_if.raw2 = 1'b0;
      reset = 1'b1;
      repeat (8) tick();
      chk_all_zero("post_rst");

      // Clean press on raw1: present after E+5, arrival in that cycle only, sensor after E+6.
      bus_if.raw1 = 1'b1;
      repeat (5) tick();
      chk1("press1_pres_e4", bus_if.present1, 1'b0);
      tick();
      chk1("press1_pres_e5", bus_if.present1, 1'b1);
      chk1("press1_arr_e5",  bus_if.arrival1, 1'b1);
      chk1("press1_sen_e5",  bus_if.sensor1,  1'b0);
      chk8("press1_cnt_e5",  bus_if.count1,   8'd0);
      tick();
      chk1("press1_pres_e6", bus_if.present1, 1'b1);
      chk1("press1_arr_e6",  bus_if.arrival1, 1'b0);
      chk1("press1_sen_e6",  bus_if.sensor1,  1'b1);
      chk8("press1_cnt_e6",  bus_if.count1,   8'd1);
      chk1("press1_sen2",    bus_if.sensor2,  1'b0);

      // Release raw1: falling edge filtered symmetrically, request stays pending.
      bus_if.raw1 = 1'b0;
      repeat (5) tick();
      chk1("rel1_pres_e4", bus_if.present1, 1'b1);
      tick();
      chk1("rel1_pres_e5", bus_if.present1, 1'b0);
      chk1("rel1_arr",     bus_if.arrival1, 1'b0);
      chk1("rel1_sen",     bus_if.sensor1,  1'b1);

      // New arrival coincident with clr1: set wins.
      bus_if.raw1 = 1'b1;
      repeat (6) tick();
      chk1("coin1_arr", bus_if.arrival1, 1'b1);
      bus_if.clr1 = 1'b1;
      tick();
      bus_if.clr1 = 1'b0;
      chk1("coin1_sen", bus_if.sensor1, 1'b1);
      chk8("coin1_cnt", bus_if.count1,  8'd2);
      bus_if.raw1 = 1'b0;
      repeat (7) tick();
      chk1("coin1_sen_hold", bus_if.sensor1, 1'b1);

      // Plain clr1 pulse clears the pending request next cycle.
      bus_if.clr1 = 1'b1;
      tick();
      bus_if.clr1 = 1'b0;
      chk1("clr1_sen", bus_if.sensor1, 1'b0);
      tick();
      chk1("clr1_sen_stay", bus_if.sensor1, 1'b0);

      // Glitch of 3 samples on raw2: never reaches present.
      bus_if.raw2 = 1'b1;
      repeat (3) tick();
      bus_if.raw2 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk1("glitch3_pres", bus_if.present2, 1'b0);
         chk1("glitch3_arr",  bus_if.arrival2, 1'b0);
      end
      chk1("glitch3_sen", bus_if.sensor2, 1'b0);
      chk8("glitch3_cnt", bus_if.count2,  8'd0);

      // 4 samples is just enough.
      bus_if.raw2 = 1'b1;
      repeat (4) tick();
      bus_if.raw2 = 1'b0;
      repeat (2) tick();
      chk1("pulse4_pres", bus_if.present2, 1'b1);
      chk1("pulse4_arr",  bus_if.arrival2, 1'b1);
      tick();
      chk1("pulse4_sen",  bus_if.sensor2,  1'b1);
      chk8("pulse4_cnt",  bus_if.count2,   8'd1);
      repeat (4) tick();
      chk1("pulse4_pres_fall", bus_if.present2, 1'b0);
      bus_if.clr2 = 1'b1;
      tick();
      bus_if.clr2 = 1'b0;
      chk1("clr2_sen", bus_if.sensor2, 1'b0);

      // Saturation: clear, then 261 presses on raw2.
      bus_if.count_clr = 1'b1;
      tick();
      bus_if.count_clr = 1'b0;
      chk8("cclr_cnt1", bus_if.count1, 8'd0);
      chk8("cclr_cnt2", bus_if.count2, 8'd0);
      for (int i = 0; i < 254; i++) press2();
      chk8("sat_cnt_254", bus_if.count2, 8'd254);
      press2();
      chk8("sat_cnt_255", bus_if.count2, 8'd255);
      for (int i = 0; i < 6; i++) press2();
      chk8("sat_cnt_nowrap", bus_if.count2, 8'd255);
      chk8("sat_cnt1_idle",  bus_if.count1, 8'd0);

      // count_clr coincident with arrival2 gives 0.
      bus_if.raw2 = 1'b1;
      repeat (6) tick();
      chk1("cclr_arr2", bus_if.arrival2, 1'b1);
      bus_if.count_clr = 1'b1;
      tick();
      bus_if.count_clr = 1'b0;
      chk8("cclr_coin_cnt2", bus_if.count2, 8'd0);
      bus_if.raw2 = 1'b0;
      repeat (7) tick();
      chk8("cclr_coin_cnt2_hold", bus_if.count2, 8'd0);

      // Independence: simultaneous presses on both channels.
      bus_if.count_clr = 1'b1;
      bus_if.clr1      = 1'b1;
      bus_if.clr2      = 1'b1;
      tick();
      bus_if.count_clr = 1'b0;
      bus_if.clr1      = 1'b0;
      bus_if.clr2      = 1'b0;
      bus_if.raw1 = 1'b1;
      bus_if.raw2 = 1'b1;
      repeat (6) tick();
      chk1("both_arr1", bus_if.arrival1, 1'b1);
      chk1("both_arr2", bus_if.arrival2, 1'b1);
      tick();
      chk8("both_cnt1", bus_if.count1,  8'd1);
      chk8("both_cnt2", bus_if.count2,  8'd1);
      chk1("both_sen1", bus_if.sensor1, 1'b1);
      chk1("both_sen2", bus_if.sensor2, 1'b1);

      // Reset mid-debounce and mid-request, asserted between edges.
      bus_if.raw1 = 1'b0;
      repeat (3) tick();
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      bus_if.raw2 = 1'b0;
      tick();
      reset = 1'b1;
      repeat (4) tick();
      chk_all_zero("mid_rst_rel");

      // Fresh press after reset needs the full debounce latency.
      bus_if.raw1 = 1'b1;
      repeat (5) tick();
      chk1("after_rst_pres_e4", bus_if.present1, 1'b0);
      tick();
      chk1("after_rst_pres_e5", bus_if.present1, 1'b1);
      chk1("after_rst_arr_e5",  bus_if.arrival1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sensor_conditioner
